// File: rtl/fpu_sched_pkg.sv
// Shared types for the FPU scheduler: operand width, FPU opcode type and the
// scheduler state encoding.
package fpu_sched_pkg;

  localparam int unsigned OperandW = 32;
  localparam int unsigned OpW      = 3;

  typedef logic [OpW-1:0] fpu_op_t;

  localparam fpu_op_t OpAdd = 3'd0;
  localparam fpu_op_t OpSub = 3'd1;
  localparam fpu_op_t OpMul = 3'd2;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StResp
  } sched_state_e;

endpackage

// File: rtl/fpu_sched_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first valid requester after
// last_grant_i, wrapping, and returns it both one-hot and as an index.
module fpu_sched_rr_arbiter #(
  parameter  int unsigned NUM_REQ = 4,
  localparam int unsigned IdxW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] valid_i,
  input  logic [IdxW-1:0]    last_grant_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IdxW-1:0]    idx_o,
  output logic               any_o
);

  logic [IdxW-1:0] cand;

  // Walk candidates starting one past the last grant; the first valid one wins.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    cand    = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = IdxW'((32'(last_grant_i) + k) % NUM_REQ);
      if (!any_o && valid_i[cand]) begin
        any_o         = 1'b1;
        grant_o[cand] = 1'b1;
        idx_o         = cand;
      end
    end
  end

endmodule

// File: rtl/fpu_sched.sv
// Round-robin scheduler sharing one fixed-latency FPU between NUM_REQ requesters.
// One op in flight at a time: accept, hold operands for FPU_LAT cycles, capture
// the result and pulse resp_valid_o to the issuing requester.
// Optional feature: define FPU_SCHED_PERF_EN to add perf_ops_o / perf_wait_o.
module fpu_sched
  import fpu_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned FPU_LAT = 3,
  parameter int unsigned OP_W    = OpW
) (
  input  logic                               clk_i,
  input  logic                               reset_i,
  input  logic [NUM_REQ-1:0]                 req_valid_i,
  output logic [NUM_REQ-1:0]                 req_ready_o,
  input  logic [NUM_REQ-1:0][OperandW-1:0]   req_a_i,
  input  logic [NUM_REQ-1:0][OperandW-1:0]   req_b_i,
  input  logic [NUM_REQ-1:0][OP_W-1:0]       req_op_i,
  output logic [NUM_REQ-1:0]                 resp_valid_o,
  output logic [OperandW-1:0]                resp_data_o,
  output logic [OperandW-1:0]                fpu_a_o,
  output logic [OperandW-1:0]                fpu_b_o,
  output logic [OP_W-1:0]                    fpu_op_o,
  input  logic [OperandW-1:0]                fpu_o_i
`ifdef FPU_SCHED_PERF_EN
  ,
  output logic [31:0]                        perf_ops_o,
  output logic [31:0]                        perf_wait_o
`endif
);

  localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CntW = (FPU_LAT > 1) ? $clog2(FPU_LAT) : 1;
  localparam logic [CntW-1:0] CntInit  = CntW'(FPU_LAT - 1);
  localparam logic [IdxW-1:0] LastInit = IdxW'(NUM_REQ - 1);

  sched_state_e         state_q;
  logic [CntW-1:0]      cnt_q;
  logic [IdxW-1:0]      tag_q;
  logic [IdxW-1:0]      last_grant_q;
  logic [OperandW-1:0]  fpu_a_q;
  logic [OperandW-1:0]  fpu_b_q;
  logic [OP_W-1:0]      fpu_op_q;
  logic [OperandW-1:0]  resp_data_q;
  logic [NUM_REQ-1:0]   resp_valid_q;

  logic [NUM_REQ-1:0]   arb_grant;
  logic [IdxW-1:0]      arb_idx;
  logic                 arb_any;
  logic                 accept;

  fpu_sched_rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .valid_i      (req_valid_i),
    .last_grant_i (last_grant_q),
    .grant_o      (arb_grant),
    .idx_o        (arb_idx),
    .any_o        (arb_any)
  );

  // Grant is only offered in IDLE; gated by reset so outputs stay zero during it.
  assign accept      = arb_any && (state_q == StIdle) && !reset_i;
  assign req_ready_o = accept ? arb_grant : '0;

  assign fpu_a_o      = fpu_a_q;
  assign fpu_b_o      = fpu_b_q;
  assign fpu_op_o     = fpu_op_q;
  assign resp_data_o  = resp_data_q;
  assign resp_valid_o = resp_valid_q;

  // Scheduler FSM with operand hold, latency counter and response capture.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      tag_q        <= '0;
      last_grant_q <= LastInit;
      fpu_a_q      <= '0;
      fpu_b_q      <= '0;
      fpu_op_q     <= '0;
      resp_data_q  <= '0;
      resp_valid_q <= '0;
    end else begin
      resp_valid_q <= '0;
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            fpu_a_q      <= req_a_i[arb_idx];
            fpu_b_q      <= req_b_i[arb_idx];
            fpu_op_q     <= req_op_i[arb_idx];
            tag_q        <= arb_idx;
            last_grant_q <= arb_idx;
            cnt_q        <= CntInit;
            state_q      <= StBusy;
          end
        end
        StBusy: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CntW'(1);
          end else begin
            resp_data_q  <= fpu_o_i;
            // Pulse is registered so it lines up exactly with the RESP cycle.
            resp_valid_q <= NUM_REQ'(1) << tag_q;
            state_q      <= StResp;
          end
        end
        StResp: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

`ifdef FPU_SCHED_PERF_EN
  logic [31:0] perf_ops_q;
  logic [31:0] perf_wait_q;

  assign perf_ops_o  = perf_ops_q;
  assign perf_wait_o = perf_wait_q;

  // Saturating counters: completed ops and cycles with demand but no handshake.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      perf_ops_q  <= '0;
      perf_wait_q <= '0;
    end else begin
      if ((state_q == StResp) && (perf_ops_q != '1)) begin
        perf_ops_q <= perf_ops_q + 32'd1;
      end
      if ((|req_valid_i) && !accept && (perf_wait_q != '1)) begin
        perf_wait_q <= perf_wait_q + 32'd1;
      end
    end
  end
`endif

endmodule

// File: doc/fpu_sched.md
# fpu_sched

Round-robin scheduler that shares the single `fpu` instance between `NUM_REQ` requesters. It accepts one operation at a time over a valid/ready handshake, holds the operands stable on the FPU inputs for the fixed FPU latency, then captures the FPU output and returns it to the requester that issued the operation. It sits between the requesting engines (or BFM agents) and the `fpu` inputs `A`, `B`, `opcode` and its output `O`.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `FPU_LAT`, 3: cycles from operands presented on the `fpu` inputs to a valid `O`, ≥1.
- `OP_W`, 3: opcode width; matches the `fpu` opcode.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `req_valid` in [NUM_REQ]: requester i presents an operation.
- `req_ready` out [NUM_REQ]: one-hot grant; handshake completes on `req_valid[i] & req_ready[i]` at a rising edge.
- `req_a`, `req_b` in [NUM_REQ][32]: single-precision operands per requester.
- `req_op` in [NUM_REQ][OP_W]: opcode per requester.
- `resp_valid` out [NUM_REQ]: one-cycle pulse to the originating requester.
- `resp_data` out 32: result, valid only while some `resp_valid` bit is high.
- `fpu_a`, `fpu_b` out 32: connect to `fpu.A` and `fpu.B`.
- `fpu_op` out OP_W: connect to `fpu.opcode`.
- `fpu_o` in 32: from `fpu.O`.

## Operation
- FSM states:
  - IDLE: if any `req_valid` is high, grant the first valid index after `last_grant`, wrapping. `req_ready[g]` is combinational (IDLE and granted). At the accepting edge, latch `req_a[g]`, `req_b[g]`, `req_op[g]` into `fpu_a`, `fpu_b`, `fpu_op`; set `tag=g`, `last_grant=g`, `cnt=FPU_LAT-1`; go to BUSY. With no valid request, stay in IDLE.
  - BUSY: `fpu_*` held stable. Each edge with `cnt!=0` decrements `cnt`. The edge with `cnt==0` captures `fpu_o` into `resp_data` and goes to RESP.
  - RESP: `resp_valid[tag]` is high for exactly this cycle; next edge returns to IDLE.
- `req_ready` is all-zero outside IDLE and when no request is valid. At most one bit is ever set.
- Responses have no backpressure; requesters must sink `resp_valid` immediately.
- A requester may deassert `req_valid` before it is granted; no state is kept for it.
- In IDLE, `fpu_*` keep the last issued values. They are not zeroed.
- Reset values: state IDLE, `last_grant=NUM_REQ-1` (requester 0 has first priority), `cnt=0`, `tag=0`. All outputs are 0: `req_ready`, `resp_valid`, `resp_data`, `fpu_a`, `fpu_b`, `fpu_op`.
- Reset mid-operation: the in-flight op is abandoned. No `resp_valid` is produced, and the requester must reissue.

## Timing
- Accept at edge E0. Operands are on `fpu_*` after E0. `fpu_o` is captured at E0+FPU_LAT, `resp_valid` is high in the cycle after that edge, and the next accept is possible at E0+FPU_LAT+2.
- Throughput is one op per FPU_LAT+2 cycles when requests are back-to-back.
- Latency from accept to `resp_valid` high is FPU_LAT cycles.

## Configuration
- `FPU_SCHED_PERF_EN`, when defined, adds two outputs:
  - `perf_ops` 32: completed ops, incremented in RESP.
  - `perf_wait` 32: cycles in which `req_valid` was nonzero but no handshake occurred.
  - Both counters reset to 0 and saturate at all-ones.
- When the macro is undefined, the ports and counters are absent and the remaining behaviour is identical.

## Structure
- Package `defs` holds:
  - The FPU opcode type and operand width constant (32).
  - The `fpu_sched` state enum (IDLE, BUSY, RESP).
- Sub-module `rr_arbiter`: combinational, takes `NUM_REQ` valid bits and `last_grant`, produces a one-hot grant plus a grant index.
- `fpu_sched` instantiates `rr_arbiter` and owns the FSM, counter and hold registers.

## Test plan
- Reset checks:
  - Assert `reset` for 2 cycles with all requests valid → all outputs 0 during reset.
  - First grant after reset is requester 0.
- Single op: requester 2 issues ADD with 0x3F800000 + 0x40000000 →
  - Handshake in 1 cycle.
  - `resp_valid[2]` pulses exactly FPU_LAT cycles after the accept, with `resp_data`=0x40400000.
  - No other `resp_valid` bit is set.
- Fairness: all 4 requesters held valid for 8 ops →
  - Grant order is 0,1,2,3,0,1,2,3.
  - Accepts are spaced FPU_LAT+2 cycles apart.
  - `fpu_*` are stable throughout each BUSY.
- Wrap and skip: `last_grant`=3 with only requesters 1 and 3 valid → grant 1, then 3, then 1.
- Reset mid-op: assert `reset` on the second BUSY cycle → no `resp_valid`, state returns to IDLE, and a reissued op completes correctly.
- `FPU_SCHED_PERF_EN`: run 5 ops with one requester valid during each BUSY → `perf_ops`=5 and `perf_wait` equals the counted stall cycles.
